seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's common-anode seven-segment display. It takes the 250 Hz square wave from the system clock divider and shares one segment bus between `NUM_DIGITS` digit drivers, one digit per 250 Hz period. Each digit change is preceded by an anti-ghosting blanking interval. Display data is double-buffered: a load/ack handshake commits new values only at frame boundaries, so the display never tears.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_decode.sv | 17 +
 rtl/seg7_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyph table, blank pattern, scan FSM states.
package seg7_pkg;

   typedef enum logic {SHOW, BLANK} state_t;

   // Active-high segment pattern for a dark digit, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_OFF = 7'h00;

   // Active-high glyphs, entry 0 rightmost: 0 1 2 3 4 5 6 7 8 9 A b C d E F
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high segments; blank forces the whole digit, dp included, dark.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       blank,
   input  logic       dp_in,
   output logic [7:0] seg8     // {dp, g, f, e, d, c, b, a}
);

   // glyph lookup with blank override
   always_comb begin
      seg8 = {1'b0, SEG_OFF};
      if (!blank) seg8 = {dp_in, SEG_HEX[nib]};
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with anti-ghost blanking and
// frame-synchronous double-buffered display data.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int BLANK_CYCLES   = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk_50mhz,
   input  logic                    rst_n,
   input  logic                    clk_250hz,
   input  logic [4*NUM_DIGITS-1:0] disp_data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_blank,
   input  logic                    load,
   output logic                    load_ack,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_start
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [IW-1:0] LAST    = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] CNT_END = CW'(BLANK_CYCLES - 1);

   state_t                         state;
   logic [CW-1:0]                  cnt;
   logic [IW-1:0]                  idx, idx_nxt;
   logic                           prev, tick, run, blank_done, boundary;
   logic                           frame_r, ack_r, pend;
   logic [NUM_DIGITS-1:0][3:0]     act_nib, pend_nib;
   logic [NUM_DIGITS-1:0]          act_dp, pend_dp;
   logic [NUM_DIGITS-1:0]          zero_dig, zero_hi, dark, dig_hot;
   logic [7:0]                     seg8;

   assign tick       = clk_250hz & ~prev;
   assign idx_nxt    = (idx == LAST) ? '0 : idx + 1'b1;
   assign blank_done = (state == BLANK) && run && (cnt == CNT_END);
   assign boundary   = blank_done && (idx_nxt == '0);
   assign dig_hot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

   // scan FSM: SHOW until a tick, then BLANK_CYCLES of darkness before the next digit;
   // out of reset the counter waits for the first tick (run = 0)
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         prev    <= 1'b0;
         state   <= BLANK;
         cnt     <= '0;
         idx     <= LAST;
         run     <= 1'b0;
         frame_r <= 1'b0;
      end else begin
         prev    <= clk_250hz;
         frame_r <= 1'b0;
         case (state)
            SHOW: begin
               if (tick) begin
                  state <= BLANK;
                  cnt   <= '0;
               end
            end
            BLANK: begin
               if (!run) begin
                  if (tick) begin
                     run <= 1'b1;
                     cnt <= '0;
                  end
               end else if (cnt == CNT_END) begin
                  state   <= SHOW;
                  idx     <= idx_nxt;
                  frame_r <= (idx_nxt == '0);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

   // double buffer: pending -> active only at a frame boundary; a load in the
   // commit cycle lands in pending and waits for the following frame
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= 1'b0;
         pend_nib <= '0;
         pend_dp  <= '0;
         act_nib  <= '0;
         act_dp   <= '0;
         ack_r    <= 1'b0;
      end else begin
         ack_r <= 1'b0;
         if (boundary && pend) begin
            act_nib <= pend_nib;
            act_dp  <= pend_dp;
            pend    <= 1'b0;
            ack_r   <= 1'b1;
         end
         if (load) begin
            pend_nib <= disp_data;
            pend_dp  <= dp_in;
            pend     <= 1'b1;
         end
      end
   end

   // per-digit darkness: disabled, or a leading zero (nibble 0, no dp, all higher
   // digits likewise); digit 0 always shows when enabled
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
      assign zero_dig[k] = (act_nib[k] == 4'h0) && !act_dp[k];
      if (k == NUM_DIGITS - 1) begin : g_top
         assign zero_hi[k] = zero_dig[k];
      end else begin : g_mid
         assign zero_hi[k] = zero_dig[k] & zero_hi[k+1];
      end
      if (k == 0) begin : g_lsd
         assign dark[k] = !digit_en[k];
      end else begin : g_msd
         assign dark[k] = !digit_en[k] | (lz_blank & zero_hi[k]);
      end
   end

   seg7_decode u_dec (
      .nib   (act_nib[idx]),
      .blank (dark[idx]),
      .dp_in (act_dp[idx]),
      .seg8  (seg8)
   );

   // registered pins, one cycle behind the FSM so pulses line up with the new digit
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         seg         <= SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
         dp          <= SEG_ACTIVE_LOW;
         dig_sel     <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
         frame_start <= 1'b0;
         load_ack    <= 1'b0;
      end else begin
         frame_start <= frame_r;
         load_ack    <= ack_r;
         if (state == SHOW) begin
            seg     <= seg8[6:0] ^ {7{SEG_ACTIVE_LOW}};
            dp      <= seg8[7] ^ SEG_ACTIVE_LOW;
            dig_sel <= (dark[idx] ? '0 : dig_hot) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
         end else begin
            seg     <= SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
            dp      <= SEG_ACTIVE_LOW;
            dig_sel <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: scan order, blanking length, buffering,
// leading-zero blanking, digit enables and async reset.
module tb_seg7_scan_ctrl;

   localparam int N = 4;
   localparam int B = 6;

   logic          clk_50mhz = 1'b0;
   logic          rst_n     = 1'b0;
   logic          clk_250hz = 1'b0;
   logic [4*N-1:0] disp_data = '0;
   logic [N-1:0]  dp_in     = '0;
   logic [N-1:0]  digit_en  = '1;
   logic          lz_blank  = 1'b0;
   logic          load      = 1'b0;
   logic          load_ack, dp, frame_start;
   logic [6:0]    seg;
   logic [N-1:0]  dig_sel;

   int total = 0, bad = 0, ack_cnt = 0, fs_cnt = 0;

   seg7_scan_ctrl #(.NUM_DIGITS(N), .BLANK_CYCLES(B),
                    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
      .clk_50mhz   (clk_50mhz),
      .rst_n       (rst_n),
      .clk_250hz   (clk_250hz),
      .disp_data   (disp_data),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .lz_blank    (lz_blank),
      .load        (load),
      .load_ack    (load_ack),
      .seg         (seg),
      .dp          (dp),
      .dig_sel     (dig_sel),
      .frame_start (frame_start)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   always @(negedge clk_50mhz) begin
      if (load_ack)    ack_cnt++;
      if (frame_start) fs_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      @(negedge clk_50mhz);
      disp_data = v;
      dp_in     = d;
      load      = 1'b1;
      @(negedge clk_50mhz);
      load      = 1'b0;
   endtask

   // one scan step; eseg/edp are the active-high glyph and dp of the digit expected next
   task automatic step(input int k, input logic [6:0] eseg, input logic edp,
                       input logic dk, input logic efs, input logic eack);
      logic [6:0] xs;
      logic       xd;
      logic [3:0] xg;
      xs = dk ? 7'h7F : ~eseg;
      xd = dk ? 1'b1 : ~edp;
      xg = 4'b0001 << k;
      xg = dk ? 4'hF : ~xg;
      @(negedge clk_50mhz) clk_250hz = 1'b1;
      @(posedge clk_50mhz);
      @(negedge clk_50mhz) clk_250hz = 1'b0;
      @(posedge clk_50mhz); #1;
      chk($sformatf("blank_first_d%0d", k), {dig_sel, dp, seg}, {4'hF, 1'b1, 7'h7F});
      repeat (B - 1) @(posedge clk_50mhz);
      #1;
      chk($sformatf("blank_last_d%0d", k), {dig_sel, dp, seg}, {4'hF, 1'b1, 7'h7F});
      @(posedge clk_50mhz); #1;
      chk($sformatf("dig_sel_d%0d", k), dig_sel, xg);
      chk($sformatf("seg_d%0d", k), seg, xs);
      chk($sformatf("dp_d%0d", k), dp, xd);
      chk($sformatf("frame_start_d%0d", k), frame_start, efs);
      chk($sformatf("load_ack_d%0d", k), load_ack, eack);
      @(posedge clk_50mhz); #1;
      chk($sformatf("pulse_end_d%0d", k), {frame_start, load_ack}, 2'b00);
   endtask

   // four steps from digit 0; optional loads issued mid-frame, after digit 1 appears
   task automatic frame(input logic [3:0][6:0] s, input logic [3:0] d, input logic [3:0] dk,
                        input logic eack, input int nld, input logic [15:0] la,
                        input logic [15:0] lb, input logic [3:0] ldp);
      for (int k = 0; k < N; k++) begin
         step(k, s[k], d[k], dk[k], k == 0, (k == 0) ? eack : 1'b0);
         if (k == 1 && nld > 0) do_load(la, ldp);
         if (k == 1 && nld > 1) do_load(lb, ldp);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk_50mhz);
      #1;
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_dig_sel", dig_sel, 4'hF);
      chk("rst_pulses", {frame_start, load_ack}, 2'b00);
      @(negedge clk_50mhz) rst_n = 1'b1;
      repeat (10) @(posedge clk_50mhz);
      #1;
      chk("idle_before_tick", {dig_sel, dp, seg}, {4'hF, 1'b1, 7'h7F});

      // 0x1234 committed at the first frame; 0xABCD loaded mid-frame
      do_load(16'h1234, 4'h0);
      frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, 4'h0, 1'b1, 1, 16'hABCD, 16'h0, 4'h0);
      // ABCD shown; two loads, last one wins
      frame({7'h77, 7'h7C, 7'h39, 7'h5E}, 4'h0, 4'h0, 1'b1, 2, 16'h1111, 16'h2222, 4'h0);
      frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'h0, 4'h0, 1'b1, 1, 16'h0050, 16'h0, 4'h0);
      chk("single_ack_count", ack_cnt, 3);

      // leading-zero blanking on 0x0050, then 0x0000 with dp on digit 2
      lz_blank = 1'b1;
      frame({7'h00, 7'h00, 7'h6D, 7'h3F}, 4'h0, 4'b1100, 1'b1, 1, 16'h0000, 16'h0, 4'b0100);
      frame({7'h00, 7'h3F, 7'h3F, 7'h3F}, 4'b0100, 4'b1000, 1'b1, 1, 16'h1234, 16'h0, 4'h0);

      // digits 1 and 3 disabled: dark slots still consume a step each
      lz_blank = 1'b0;
      digit_en = 4'b0101;
      frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, 4'b1010, 1'b1, 0, 16'h0, 16'h0, 4'h0);
      frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, 4'b1010, 1'b0, 0, 16'h0, 16'h0, 4'h0);

      // reset while showing digit 0 with a load pending
      step(0, 7'h66, 1'b0, 1'b0, 1'b1, 1'b0);
      do_load(16'h9999, 4'hF);
      @(negedge clk_50mhz) rst_n = 1'b0;
      #1;
      chk("async_rst_seg", seg, 7'h7F);
      chk("async_rst_dp", dp, 1'b1);
      chk("async_rst_dig_sel", dig_sel, 4'hF);
      repeat (3) @(posedge clk_50mhz);
      @(negedge clk_50mhz) rst_n = 1'b1;
      digit_en = 4'hF;
      step(0, 7'h3F, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1, 7'h3F, 1'b0, 1'b0, 1'b0, 1'b0);

      chk("total_acks", ack_cnt, 6);
      chk("total_frames", fs_cnt, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
